// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target controller: FSM state encoding,
// bus-level constants and the address-match helper.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        WR_DATA  = 3'd3,
        WR_ACK   = 3'd4,
        RD_DATA  = 3'd5,
        RD_ACK   = 3'd6
    } state_e;

    localparam logic I2C_ACK     = 1'b0;
    localparam logic I2C_NACK    = 1'b1;
    localparam logic I2C_RW_READ = 1'b1;

    // The general-call address is never claimed, even if configured as ours.
    function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] target);
        return (addr_byte[7:1] == target) && (addr_byte[7:1] != 7'h00);
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchroniser, glitch filter and edge detector for one open-drain bus line.
// Pin-to-pulse latency is SYNC_STAGES + GLITCH_CYC clock cycles.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int GLITCH_CYC  = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CNT_W = $clog2(GLITCH_CYC + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   filt_q, filt_d;
    logic                   prev_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    // Idle bus level is high, so preset to 1 to avoid spurious edges after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
            filt_q <= 1'b1;
            prev_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
            filt_q <= filt_d;
            prev_q <= filt_q;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync_q[SYNC_STAGES-1] != filt_q) begin
            if (cnt_q == CNT_W'(GLITCH_CYC - 1)) begin
                filt_d = sync_q[SYNC_STAGES-1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign level_o = filt_q;
    assign rise_o  = filt_q & ~prev_q;
    assign fall_o  = ~filt_q & prev_q;

endmodule

// File: rtl/i2c_target_ctrl.sv
// I2C target controller: START/STOP detection, 7-bit address match and
// byte-stream write/read transfers with per-byte ACK/NACK.
module i2c_target_ctrl #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         SYNC_STAGES = 2,
    parameter int         GLITCH_CYC  = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_full,
    input  logic [7:0] tx_data,
    output logic       tx_pop,
    output logic       start_det,
    output logic       stop_det,
    output logic       busy,
    output logic       rw
);
    import i2c_pkg::*;

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES), .GLITCH_CYC(GLITCH_CYC)) u_scl_sync (
        .clk(clk), .reset_n(reset_n), .line_i(scl),
        .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
    );

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES), .GLITCH_CYC(GLITCH_CYC)) u_sda_sync (
        .clk(clk), .reset_n(reset_n), .line_i(sda),
        .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
    );

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] sh_q, sh_d;
    logic       oe_q, oe_d;
    logic       ack_clk_q, ack_clk_d;
    logic       drop_q, drop_d;
    logic       rw_q, rw_d;
    logic       busy_q, busy_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_pop_q, tx_pop_d;
    logic       start_q, stop_q;
    logic       start, stop, rd_load;
    logic [7:0] byte_in;

    assign start = sda_fall & scl_lvl;
    assign stop  = sda_rise & scl_lvl;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            sh_q       <= 8'h00;
            oe_q       <= 1'b0;
            ack_clk_q  <= 1'b0;
            drop_q     <= 1'b0;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_pop_q   <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            sh_q       <= sh_d;
            oe_q       <= oe_d;
            ack_clk_q  <= ack_clk_d;
            drop_q     <= drop_d;
            rw_q       <= rw_d;
            busy_q     <= busy_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_pop_q   <= tx_pop_d;
            start_q    <= start;
            stop_q     <= stop;
        end
    end

    // ACK states use ack_clk_q to tell the fall opening the slot from the one closing it.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        sh_d       = sh_q;
        oe_d       = oe_q;
        ack_clk_d  = ack_clk_q;
        drop_d     = drop_q;
        rw_d       = rw_q;
        busy_d     = busy_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_pop_d   = 1'b0;
        rd_load    = 1'b0;
        byte_in    = {sh_q[6:0], sda_lvl};

        if (start) begin
            state_d   = ADDR;
            bit_cnt_d = 3'd0;
            oe_d      = 1'b0;
            ack_clk_d = 1'b0;
            busy_d    = 1'b0;
        end else if (stop) begin
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
            oe_d      = 1'b0;
            ack_clk_d = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ADDR: if (scl_rise) begin
                    sh_d      = byte_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (addr_match(byte_in, TARGET_ADDR)) begin
                            state_d   = ADDR_ACK;
                            rw_d      = byte_in[0];
                            busy_d    = 1'b1;
                            ack_clk_d = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_rise) ack_clk_d = 1'b1;
                    if (scl_fall) begin
                        if (!ack_clk_q) begin
                            oe_d = 1'b1;
                        end else if (rw_q == I2C_RW_READ) begin
                            rd_load = 1'b1;
                        end else begin
                            state_d   = WR_DATA;
                            oe_d      = 1'b0;
                            ack_clk_d = 1'b0;
                        end
                    end
                end
                WR_DATA: if (scl_rise) begin
                    sh_d      = byte_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d  = byte_in;
                        rx_valid_d = ~rx_full;
                        drop_d     = rx_full;
                        state_d    = WR_ACK;
                    end
                end
                WR_ACK: begin
                    if (scl_rise) ack_clk_d = 1'b1;
                    if (scl_fall) begin
                        if (!ack_clk_q) begin
                            oe_d = (drop_q == I2C_ACK);
                        end else begin
                            state_d   = WR_DATA;
                            oe_d      = 1'b0;
                            ack_clk_d = 1'b0;
                        end
                    end
                end
                RD_DATA: begin
                    if (scl_fall) oe_d = ~sh_q[3'd7 - bit_cnt_q];
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_d = RD_ACK;
                    end
                end
                RD_ACK: begin
                    if (scl_fall) begin
                        if (ack_clk_q) rd_load = 1'b1;
                        else           oe_d    = 1'b0;
                    end
                    if (scl_rise) begin
                        if (sda_lvl == I2C_NACK) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end else begin
                            ack_clk_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            if (rd_load) begin
                state_d   = RD_DATA;
                sh_d      = tx_data;
                oe_d      = ~tx_data[7];
                tx_pop_d  = 1'b1;
                bit_cnt_d = 3'd0;
                ack_clk_d = 1'b0;
            end
        end
    end

    assign sda       = oe_q ? 1'b0 : 1'bz;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign tx_pop    = tx_pop_q;
    assign start_det = start_q;
    assign stop_det  = stop_q;
    assign busy      = busy_q;
    assign rw        = rw_q;

endmodule
